// File: rtl/prime_sweep_ctrl.sv
// Sweeps [range_lo, range_hi] through an external combinational prime detector and streams the primes through a small valid/ready FIFO.
// Optional build macro PRIME_SWEEP_SKIP_EVEN_EN: present only 0, 1, 2, 3 and odd candidates.
module prime_sweep_ctrl #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] range_lo,
    input  logic [WIDTH-1:0] range_hi,
    output logic [WIDTH-1:0] num,
    input  logic             is_prime,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic [WIDTH-1:0] prime_data,
    output logic [WIDTH-1:0] prime_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: an entry moves on a clock edge where prime_valid && prime_ready are both high;
    // prime_data stays stable while prime_valid is high and prime_ready is low.

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             stall;
    logic             last;
    logic [WIDTH-1:0] lo_eff;
    logic [WIDTH-1:0] num_next;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO stalls the candidate even if the head is popped this cycle.
    assign push  = (state_q == S_SCAN) && is_prime && !fifo_full;
    assign stall = (state_q == S_SCAN) && is_prime && fifo_full;
    assign pop   = !fifo_empty && prime_ready;

`ifdef PRIME_SWEEP_SKIP_EVEN_EN
    logic [WIDTH-1:0] step;

    // 0..3 are stepped by one so that 2 and 3 are both presented; odd values from 3 upward step by two.
    assign step     = (num_q >= WIDTH'(3) && num_q[0]) ? WIDTH'(2) : WIDTH'(1);
    assign lo_eff   = (!range_lo[0] && range_lo >= WIDTH'(4)) ? range_lo + WIDTH'(1) : range_lo;
    assign last     = ({1'b0, num_q} + {1'b0, step}) > {1'b0, hi_q};
    assign num_next = num_q + step;
`else
    assign lo_eff   = range_lo;
    assign last     = (num_q == hi_q);
    assign num_next = num_q + WIDTH'(1);
`endif

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        hi_d     = hi_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (lo_eff > range_hi) begin
                        state_d = S_DONE;
                    end else begin
                        hi_d    = range_hi;
                        num_d   = lo_eff;
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (push && count_q != {WIDTH{1'b1}}) begin
                    count_d = count_q + WIDTH'(1);
                end
                // Termination is checked before stepping so num never wraps past hi.
                if (!stall) begin
                    if (last) begin
                        state_d = S_FLUSH;
                    end else begin
                        num_d = num_next;
                    end
                end
            end
            S_FLUSH: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            hi_q     <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            hi_q     <= hi_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= num_q;
            end
        end
    end

    assign num         = num_q;
    assign prime_valid = !fifo_empty;
    assign prime_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign prime_count = count_q;
    assign busy        = (state_q == S_SCAN) || (state_q == S_FLUSH);
    assign done        = (state_q == S_DONE);
    assign state_dbg   = state_q;

endmodule
